// File: rtl/data_ram_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_access_ctrl_if
// Description : Write-master, read-port and RAM-side bundle for the data RAM
//               access controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_ram_access_ctrl_if #(
  parameter int NUM_WR = 2,
  parameter int ADDR_W = 1,
  parameter int DATA_W = 8
);
  logic [NUM_WR-1:0]        m_write;
  logic [NUM_WR*ADDR_W-1:0] m_address;
  logic [NUM_WR*DATA_W-1:0] m_writedata;
  logic [NUM_WR-1:0]        m_waitrequest;
  logic [NUM_WR-1:0]        m_grant;
  logic                     rd_read;
  logic [ADDR_W-1:0]        rd_address;
  logic [DATA_W-1:0]        rd_readdata;
  logic                     rd_readdatavalid;
  logic [ADDR_W-1:0]        ram_wr_address;
  logic [DATA_W-1:0]        ram_wr_writedata;
  logic                     ram_wr_write;
  logic                     ram_wr_waitrequest;
  logic [ADDR_W-1:0]        ram_rd_address;
  logic [DATA_W-1:0]        ram_rd_readdata;
  logic                     ready;

  modport slave (
    input  m_write, m_address, m_writedata,
    output m_waitrequest, m_grant,
    input  rd_read, rd_address,
    output rd_readdata, rd_readdatavalid,
    output ram_wr_address, ram_wr_writedata, ram_wr_write,
    input  ram_wr_waitrequest,
    output ram_rd_address,
    input  ram_rd_readdata,
    output ready
  );

  modport master (
    output m_write, m_address, m_writedata,
    input  m_waitrequest, m_grant,
    output rd_read, rd_address,
    input  rd_readdata, rd_readdatavalid,
    input  ram_wr_address, ram_wr_writedata, ram_wr_write,
    output ram_wr_waitrequest,
    input  ram_rd_address,
    output ram_rd_readdata,
    input  ready
  );
endinterface
`default_nettype wire

// File: rtl/data_ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_access_ctrl
// Description : Arbitrates NUM_WR write masters onto the data RAM write port
//               in bounded bursts and pipelines single-beat reads.
//               DATA_RAM_ACCESS_CTRL_RR_EN selects round-robin arbitration;
//               undefined gives fixed lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_access_ctrl #(
  parameter int NUM_WR     = 2,
  parameter int ADDR_W     = 1,
  parameter int DATA_W     = 8,
  parameter int MAX_BURST  = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  data_ram_access_ctrl_if.slave  bus
);
  localparam int         IDX_W       = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_WR-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]      gidx_q, gidx_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [RD_LATENCY-1:0] rdpipe_q, rdpipe_d;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_vld;
  logic                  ready_w;
  logic                  wr_acc;

`ifdef DATA_RAM_ACCESS_CTRL_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  // Walk from the farthest slot back to the pointer so the nearest request wins.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = NUM_WR - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_WR);
      if (bus.m_write[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_BURST && state_d == ST_IDLE)
      ptr_d = (gidx_q == IDX_W'(NUM_WR - 1)) ? '0 : gidx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = NUM_WR - 1; k >= 0; k--) begin
      if (bus.m_write[IDX_W'(k)]) begin
        win_idx = IDX_W'(k);
        win_vld = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    gidx_d             = gidx_q;
    cnt_d              = cnt_q;
    ready_w            = 1'b0;
    wr_acc             = 1'b0;
    bus.m_waitrequest  = '1;
    bus.ram_wr_write   = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (!bus.ram_wr_waitrequest) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        ready_w = 1'b1;
        if (bus.ram_wr_waitrequest) begin
          state_d = ST_INIT;
        end else if (win_vld) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = win_idx;
          state_d          = ST_BURST;
        end
      end
      ST_BURST: begin
        ready_w = 1'b1;
        if (bus.ram_wr_waitrequest) begin
          state_d = ST_INIT;
          grant_d = '0;
          cnt_d   = '0;
        end else begin
          // A beat coinciding with reset is neither written nor acknowledged.
          wr_acc                    = bus.m_write[gidx_q] & ~reset;
          bus.m_waitrequest[gidx_q] = reset;
          bus.ram_wr_write          = wr_acc;
          if (wr_acc) cnt_d = cnt_q + 4'd1;
          if (!bus.m_write[gidx_q] || cnt_d == C_MAX_BURST) begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    rdpipe_d    = '0;
    rdpipe_d[0] = bus.rd_read & ready_w;
    for (int i = 1; i < RD_LATENCY; i++) rdpipe_d[i] = rdpipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      grant_q  <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
      rdpipe_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
      rdpipe_q <= rdpipe_d;
    end
  end

  assign bus.m_grant          = grant_q;
  assign bus.ready            = ready_w;
  assign bus.ram_wr_address   = bus.m_address[gidx_q*ADDR_W +: ADDR_W];
  assign bus.ram_wr_writedata = bus.m_writedata[gidx_q*DATA_W +: DATA_W];
  assign bus.ram_rd_address   = bus.rd_address;
  assign bus.rd_readdata      = bus.ram_rd_readdata;
  assign bus.rd_readdatavalid = rdpipe_q[RD_LATENCY-1];
endmodule
`default_nettype wire

// File: tb/tb_data_ram_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_access_ctrl
// Description : Self-checking bench for data_ram_access_ctrl with a small RAM
//               model; expected RAM writes and read data are queued up front.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_access_ctrl;
  localparam int NUM_WR = 2, ADDR_W = 1, DATA_W = 8, MAX_BURST = 4, RD_LATENCY = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_ram_access_ctrl_if #(.NUM_WR(NUM_WR), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_ram_access_ctrl #(
    .NUM_WR(NUM_WR), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MAX_BURST(MAX_BURST), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model with a two-cycle read pipeline
  logic [DATA_W-1:0] mem [2];
  logic [DATA_W-1:0] rd_s0, rd_s1;
  always @(posedge clk) begin
    if (bus.ram_wr_write) mem[bus.ram_wr_address] <= bus.ram_wr_writedata;
    rd_s0 <= mem[bus.ram_rd_address];
    rd_s1 <= rd_s0;
  end
  assign bus.ram_rd_readdata = rd_s1;

  logic [ADDR_W+DATA_W-1:0] exp_wr[$];
  logic [DATA_W-1:0]        exp_rd[$];
  logic [NUM_WR-1:0]        exp_gnt[$];
  logic [DATA_W-1:0]        exp_mem [2];
  int n_total = 0;
  int n_pass  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    bus.ram_wr_waitrequest = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    bus.m_write = '0; bus.m_address = '0; bus.m_writedata = '0;
    bus.rd_read = 1'b0; bus.rd_address = '0; bus.ram_wr_waitrequest = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({bus.ready, bus.m_waitrequest, bus.m_grant, bus.rd_readdatavalid, bus.ram_wr_write} !== 7'b0_11_00_0_0)
      $display("FAIL reset_values: got %b expected 0110000",
               {bus.ready, bus.m_waitrequest, bus.m_grant, bus.rd_readdatavalid, bus.ram_wr_write});
    else n_pass++;
    tick();
    reset = 1'b0;
    bus.rd_read = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) begin bus.ram_wr_waitrequest = 1'b0; bus.rd_read = 1'b0; end
      @(negedge clk);
      n_total++;
      if (bus.ready !== (c == 6)) $display("FAIL init_ready c%0d: got %b expected %b", c, bus.ready, (c == 6));
      else n_pass++;
      n_total++;
      if (bus.rd_readdatavalid !== 1'b0) $display("FAIL init_read_ignored c%0d: got %b expected 0", c, bus.rd_readdatavalid);
      else n_pass++;
      if (c < 5) begin
        n_total++;
        if (bus.m_waitrequest !== 2'b11) $display("FAIL init_stall c%0d: got %b expected 11", c, bus.m_waitrequest);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_burst();
    bit pat [8];
    int beat, cyc;
    logic acc;
    logic [ADDR_W+DATA_W-1:0] got;
    pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    beat = 0; cyc = 0;
    bus.m_write = 2'b01; bus.m_address = '0; bus.m_writedata[7:0] = 8'h11;
    for (int j = 0; j < 6; j++) exp_wr.push_back({1'b0, 8'h11 + 8'(j)});
    exp_mem[0] = 8'h16;
    while (beat < 6 && cyc < 30) begin
      @(negedge clk);
      if (cyc < 8) begin
        n_total++;
        if ({bus.ram_wr_write, bus.m_grant} !== {pat[cyc], (pat[cyc] ? 2'b01 : 2'b00)})
          $display("FAIL burst_shape c%0d: got wr=%b gnt=%b expected wr=%b", cyc, bus.ram_wr_write, bus.m_grant, pat[cyc]);
        else n_pass++;
      end
      if (bus.ram_wr_write) begin
        got = {bus.ram_wr_address, bus.ram_wr_writedata};
        n_total++;
        if (exp_wr.size() == 0) $display("FAIL burst_write: got %h expected none", got);
        else if (got !== exp_wr[0]) begin $display("FAIL burst_write: got %h expected %h", got, exp_wr[0]); void'(exp_wr.pop_front()); end
        else begin n_pass++; void'(exp_wr.pop_front()); end
      end
      acc = bus.m_write[0] & ~bus.m_waitrequest[0];
      tick();
      cyc++;
      if (acc) begin
        beat++;
        if (beat < 6) bus.m_writedata[7:0] = 8'h11 + 8'(beat);
        else bus.m_write = '0;
      end
    end
    n_total++;
    if (beat != 6) $display("FAIL burst_timeout: got %0d beats expected 6", beat);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.ram_wr_write !== 1'b0 || exp_wr.size() != 0)
      $display("FAIL burst_end: got wr=%b pending=%0d expected wr=0 pending=0", bus.ram_wr_write, exp_wr.size());
    else n_pass++;
    tick();
    bus.rd_read = 1'b1; bus.rd_address = 1'b0;
    exp_rd.push_back(exp_mem[0]);
    tick();
    bus.rd_read = 1'b0;
    begin : wait_rd
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bus.rd_readdatavalid) begin
          n_total++;
          if (bus.rd_readdata !== exp_rd[0]) $display("FAIL burst_readback: got %h expected %h", bus.rd_readdata, exp_rd[0]);
          else n_pass++;
          void'(exp_rd.pop_front());
          tick();
          disable wait_rd;
        end
        tick();
      end
      n_total++;
      $display("FAIL burst_readback_timeout: got no valid expected %h", exp_rd[0]);
      exp_rd.delete();
    end
  endtask

  task automatic test_read_b2b();
    logic exp_v;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        bus.rd_read = 1'b1; bus.rd_address = ADDR_W'(c % 2);
        exp_rd.push_back(exp_mem[c % 2]);
      end else bus.rd_read = 1'b0;
      @(negedge clk);
      exp_v = (c >= 2 && c < 10);
      n_total++;
      if (bus.rd_readdatavalid !== exp_v) $display("FAIL rd_valid c%0d: got %b expected %b", c, bus.rd_readdatavalid, exp_v);
      else n_pass++;
      if (bus.rd_readdatavalid && exp_rd.size() != 0) begin
        n_total++;
        if (bus.rd_readdata !== exp_rd[0]) $display("FAIL rd_data c%0d: got %h expected %h", c, bus.rd_readdata, exp_rd[0]);
        else n_pass++;
        void'(exp_rd.pop_front());
      end
      tick();
    end
    exp_rd.delete();
  endtask

  task automatic test_arbitration();
    int n [2];
    int seen, cyc, own;
    logic acc0, acc1;
    logic [NUM_WR-1:0] prev;
    logic [ADDR_W+DATA_W-1:0] got;
    reset_dut();
    n[0] = 0; n[1] = 0;
    for (int b = 0; b < 3; b++) begin
`ifdef DATA_RAM_ACCESS_CTRL_RR_EN
      own = b % 2;
`else
      own = 0;
`endif
      exp_gnt.push_back(own == 0 ? 2'b01 : 2'b10);
      for (int j = 0; j < 4; j++) begin
        exp_wr.push_back({1'(own), (own == 0 ? 8'hA0 : 8'hB0) + 8'(n[own])});
        exp_mem[own] = (own == 0 ? 8'hA0 : 8'hB0) + 8'(n[own]);
        n[own]++;
      end
    end
    n[0] = 0; n[1] = 0; seen = 0; cyc = 0; prev = '0;
    bus.m_address = 2'b10; bus.m_writedata = {8'hB0, 8'hA0}; bus.m_write = 2'b11;
    while (seen < 12 && cyc < 60) begin
      @(negedge clk);
      if (bus.ram_wr_write) begin
        got = {bus.ram_wr_address, bus.ram_wr_writedata};
        seen++;
        n_total++;
        if (exp_wr.size() == 0) $display("FAIL arb_write: got %h expected none", got);
        else if (got !== exp_wr[0]) begin $display("FAIL arb_write: got %h expected %h", got, exp_wr[0]); void'(exp_wr.pop_front()); end
        else begin n_pass++; void'(exp_wr.pop_front()); end
      end
      if (bus.m_grant != '0 && prev == '0) begin
        n_total++;
        if (exp_gnt.size() == 0) $display("FAIL arb_grant: got %b expected none", bus.m_grant);
        else if (bus.m_grant !== exp_gnt[0]) begin $display("FAIL arb_grant: got %b expected %b", bus.m_grant, exp_gnt[0]); void'(exp_gnt.pop_front()); end
        else begin n_pass++; void'(exp_gnt.pop_front()); end
      end
      prev = bus.m_grant;
      acc0 = bus.m_write[0] & ~bus.m_waitrequest[0];
      acc1 = bus.m_write[1] & ~bus.m_waitrequest[1];
      tick();
      cyc++;
      if (acc0) begin n[0]++; bus.m_writedata[7:0]  = 8'hA0 + 8'(n[0]); end
      if (acc1) begin n[1]++; bus.m_writedata[15:8] = 8'hB0 + 8'(n[1]); end
    end
    bus.m_write = '0;
    n_total++;
    if (seen != 12 || exp_wr.size() != 0 || exp_gnt.size() != 0)
      $display("FAIL arb_complete: got writes=%0d pending_wr=%0d pending_gnt=%0d expected 12/0/0", seen, exp_wr.size(), exp_gnt.size());
    else n_pass++;
    exp_wr.delete(); exp_gnt.delete();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [ADDR_W+DATA_W-1:0] got;
    logic done;
    bus.m_address = '0; bus.m_writedata[7:0] = 8'hC1; bus.m_write = 2'b01;
    exp_wr.push_back({1'b0, 8'hC1});
    tick();                                   // grant cycle
    @(negedge clk);
    got = {bus.ram_wr_address, bus.ram_wr_writedata};
    n_total++;
    if (bus.ram_wr_write !== 1'b1 || got !== exp_wr[0]) $display("FAIL mid_beat1: got wr=%b %h expected wr=1 %h", bus.ram_wr_write, got, exp_wr[0]);
    else n_pass++;
    void'(exp_wr.pop_front());
    tick();
    bus.m_writedata[7:0] = 8'hC2;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.ram_wr_write !== 1'b0) $display("FAIL mid_beat2_dropped: got wr=%b expected 0", bus.ram_wr_write);
    else n_pass++;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.m_grant, bus.m_waitrequest, bus.ram_wr_write, bus.ready} !== 6'b00_11_0_0)
      $display("FAIL mid_after_reset: got %b expected 001100", {bus.m_grant, bus.m_waitrequest, bus.ram_wr_write, bus.ready});
    else n_pass++;
    exp_wr.push_back({1'b0, 8'hC2});
    exp_mem[0] = 8'hC2;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      tick();
      @(negedge clk);
      if (bus.ram_wr_write) begin
        got = {bus.ram_wr_address, bus.ram_wr_writedata};
        n_total++;
        if (got !== exp_wr[0]) $display("FAIL mid_resume: got %h expected %h", got, exp_wr[0]);
        else n_pass++;
        void'(exp_wr.pop_front());
        done = 1'b1;
      end
    end
    n_total++;
    if (!done) $display("FAIL mid_resume_timeout: got no write expected %h", exp_wr[0]);
    else n_pass++;
    tick();
    bus.m_write = '0;
    exp_wr.delete();
    tick();
    tick();
  endtask

  initial begin
    mem[0] = '0; mem[1] = '0;
    exp_mem[0] = '0; exp_mem[1] = '0;
    test_reset();
    test_burst();
    test_read_b2b();
    test_arbitration();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
